// File: rtl/div_iter_unit_pkg.sv
// Shared core definitions: XLEN, divide op encodings, divider states.
// Imported by decode, the ALU and the iterative divider.
package div_iter_unit_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } div_state_e;

  function automatic logic op_signed(div_op_e o);
    return ~o[0];
  endfunction

  function automatic logic op_rem(div_op_e o);
    return o[1];
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration, purely combinational.
// Ports: rem_in/quo_in/dvs in, rem_out/quo_out out (all XLEN wide).
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] shl;
  logic [XLEN:0] diff;

  // rem_in < dvs always holds, so diff[XLEN] is a clean borrow flag
  assign shl  = {rem_in, quo_in[XLEN-1]};
  assign diff = shl - {1'b0, dvs};

  assign rem_out = diff[XLEN] ? shl[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_out = {quo_in[XLEN-2:0], ~diff[XLEN]};

endmodule

// File: rtl/div_iter_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one bit per cycle.
// Ports: clk, rst, start, op, dividend, divisor, kill -> busy, done, result.
module div_iter_unit
  import div_iter_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e state, state_n;

  logic            accept;
  logic            last;
  logic            sel_rem;
  logic            neg_q;
  logic            neg_r;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dvs;
  logic [XLEN-1:0] res;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;

  div_op_e         op_in;
  logic            sgn;
  logic            a_neg;
  logic            b_neg;
  logic            dz;
  logic            ovf;
  logic            special;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;

  assign op_in   = div_op_e'(op);
  assign sgn     = op_signed(op_in);
  assign a_neg   = sgn & dividend[XLEN-1];
  assign b_neg   = sgn & divisor[XLEN-1];
  assign a_mag   = a_neg ? -dividend : dividend;
  assign b_mag   = b_neg ? -divisor : divisor;
  assign dz      = (divisor == '0);
  assign ovf     = sgn & (dividend == MIN_NEG) & (&divisor);
  assign special = dz | ovf;

  assign last  = (cnt == CW'(XLEN-1));
  assign q_fix = neg_q ? -quo : quo;
  assign r_fix = neg_r ? -rem : rem;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem),
    .quo_in  (quo),
    .dvs     (dvs),
    .rem_out (rem_nx),
    .quo_out (quo_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // kill outranks start; a start in DONE is accepted back-to-back
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        state_n = S_IDLE;
        if (!kill && start) begin
          accept  = 1'b1;
          state_n = special ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        if (kill)      state_n = S_IDLE;
        else if (last) state_n = S_FIX;
      end
      S_FIX: state_n = kill ? S_IDLE : S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

  // special cases preload quo/rem with the final answer and skip CALC
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_rem <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      res     <= '0;
    end else begin
      if (accept) begin
        sel_rem <= op_rem(op_in);
        cnt     <= '0;
        dvs     <= b_mag;
        if (dz) begin
          quo   <= '1;
          rem   <= dividend;
          neg_q <= 1'b0;
          neg_r <= 1'b0;
        end else if (ovf) begin
          quo   <= MIN_NEG;
          rem   <= '0;
          neg_q <= 1'b0;
          neg_r <= 1'b0;
        end else begin
          quo   <= a_mag;
          rem   <= '0;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
        end
      end else if (state == S_CALC) begin
        rem <= rem_nx;
        quo <= quo_nx;
        cnt <= cnt + CW'(1);
      end
      if (state == S_FIX && !kill)
        res <= sel_rem ? r_fix : q_fix;
    end
  end

  assign busy   = (state == S_CALC) || (state == S_FIX);
  assign done   = (state == S_DONE);
  assign result = res;

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed self-checking bench for div_iter_unit.
// Latencies are counted in cycles after the accepting cycle N.
module tb_div_iter_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;
  int n;
  logic hit;

  div_iter_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .kill     (kill),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    int k;
    logic h;
    @(negedge clk);
    op = o; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dividend = 32'hDEADBEEF;
    divisor  = 32'h3;
    k = 1;
    h = 1'b0;
    while (k < 100 && !h) begin
      @(negedge clk);
      if (k == 1) check({tag, "_busy"}, 64'(busy), 64'd1);
      if (done) h = 1'b1;
      else begin
        @(posedge clk);
        k++;
      end
    end
    check({tag, "_lat"}, 64'(k), 64'(lat));
    check({tag, "_res"}, 64'(result), 64'(exp));
    check({tag, "_idle"}, 64'(busy), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; kill = 1'b0;
    op = 2'b00; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_res", 64'(result), 64'd0);
    rst = 1'b0;

    run_op("div_20_m3", 2'b00, 32'd20, 32'hFFFFFFFD, 32'hFFFFFFFA, 34);
    run_op("rem_20_m3", 2'b10, 32'd20, 32'hFFFFFFFD, 32'd2, 34);
    run_op("divu_max_2", 2'b01, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 34);
    run_op("remu_max_2", 2'b11, 32'hFFFFFFFF, 32'd2, 32'd1, 34);
    run_op("div_7_0", 2'b00, 32'd7, 32'd0, 32'hFFFFFFFF, 2);
    run_op("rem_7_0", 2'b10, 32'd7, 32'd0, 32'd7, 2);
    run_op("div_ovf", 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
    run_op("rem_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 2);
    run_op("divu_big_m1", 2'b01, 32'h80000000, 32'hFFFFFFFF, 32'd0, 34);
    run_op("div_m7_2", 2'b00, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
    run_op("rem_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);

    // kill in cycle N+10
    @(negedge clk);
    op = 2'b01; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 1;
    hit = 1'b0;
    while (n < 10) begin
      @(negedge clk);
      if (done) hit = 1'b1;
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    if (done) hit = 1'b1;
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    if (done) hit = 1'b1;
    check("kill_busy", 64'(busy), 64'd0);
    check("kill_nodone", 64'(hit), 64'd0);
    check("kill_res", 64'(result), 64'hFFFFFFFF);
    @(posedge clk);
    run_op("after_kill", 2'b01, 32'd50, 32'd5, 32'd10, 34);

    // start held through busy, re-accepted in the DONE cycle
    @(negedge clk);
    op = 2'b01; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 dividend = 32'd1000;
    divisor = 32'd10;
    n = 1;
    hit = 1'b0;
    while (n < 100 && !hit) begin
      @(negedge clk);
      if (n == 5) check("b2b_busy", 64'(busy), 64'd1);
      if (done) hit = 1'b1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    check("b2b_lat1", 64'(n), 64'd34);
    check("b2b_res1", 64'(result), 64'd14);
    @(posedge clk);
    #1 start = 1'b0;
    n = 1;
    hit = 1'b0;
    while (n < 100 && !hit) begin
      @(negedge clk);
      if (done) hit = 1'b1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    check("b2b_gap", 64'(n), 64'd34);
    check("b2b_res2", 64'(result), 64'd100);
    @(posedge clk);

    // reset in flight
    @(negedge clk);
    op = 2'b00; dividend = 32'd20; divisor = 32'hFFFFFFFD; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_abort_busy", 64'(busy), 64'd0);
    check("rst_abort_res", 64'(result), 64'd0);
    hit = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) hit = 1'b1;
    end
    check("rst_abort_nodone", 64'(hit), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_iter_unit.md
DIV_ITER_UNIT -- requirements
Module: div_iter_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have port clk, input, 1, single rising-edge clock.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request a divide; sampled only when the unit is not busy.
REQ-005 SHALL have port op, input, 2, operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 SHALL have port dividend, input, XLEN, rs1 value.
REQ-007 SHALL have port divisor, input, XLEN, rs2 value.
REQ-008 SHALL have port kill, input, 1, pipeline flush; abort the current operation.
REQ-009 SHALL have port busy, output, 1, operation in progress; upstream stalls while high.
REQ-010 SHALL have port done, output, 1, single-cycle pulse when result is valid for writeback.
REQ-011 SHALL have port result, output, XLEN, quotient or remainder per op.

Function
REQ-012 SHALL implement states IDLE, CALC, FIX, DONE.
- IDLE/DONE + start: go to CALC, or to FIX directly on a special case.
- CALC: after XLEN iterations go to FIX.
- FIX: go to DONE.
- DONE: go to IDLE when start is absent.
REQ-013 SHALL capture op, dividend and divisor on the accepting edge; later input changes SHALL NOT affect the result.
REQ-014 SHALL perform one restoring-division step per CALC cycle: shift remainder:quotient left by 1, trial-subtract |divisor|, set the quotient bit.
REQ-015 SHALL, for DIV/REM, divide magnitudes and apply signs in FIX.
- Quotient is negative iff the operand signs differ.
- Remainder takes the dividend's sign.
REQ-016 SHALL, for a normal operation accepted in cycle N, assert done in cycle N+XLEN+2 (N+34 for XLEN=32).
REQ-017 SHALL treat divisor==0 as a special case, done in cycle N+2.
- Quotient = all ones.
- Remainder = dividend.
REQ-018 SHALL treat signed overflow (DIV/REM, dividend=0x80000000, divisor=0xFFFFFFFF) as a special case, done in cycle N+2.
- Quotient = 0x80000000.
- Remainder = 0.
REQ-019 SHALL keep busy high from the cycle after acceptance through the FIX cycle, and low in IDLE and DONE.
REQ-020 SHALL hold done high for exactly one cycle per completed operation.
REQ-021 SHALL keep result stable from done until the next done, across kill and ignored starts.
REQ-022 SHALL ignore start while in CALC or FIX; no queuing.
REQ-023 SHALL accept a start that arrives in the DONE cycle (back-to-back issue); done SHALL still pulse for the finishing operation.
REQ-024 SHALL, on kill in CALC or FIX, go to IDLE on the next edge with no done pulse and result unchanged.
REQ-025 SHALL give kill priority over start when both are asserted in the same cycle; that start is not accepted.

Reset
REQ-026 SHALL, when rst is sampled high, set state=IDLE, busy=0, done=0, result=0 and clear all internal registers.
REQ-027 SHALL abort an in-flight operation on reset, with no done pulse afterwards.
REQ-028 SHALL give rst priority over kill and start.

Structure
REQ-029 SHALL take op encodings, state encodings and XLEN from the shared core definitions package, shared with decode and the ALU.
REQ-030 SHALL place one restoring iteration in sub-module div_step: combinational, remainder/quotient/divisor in, next remainder/quotient out.
REQ-031 SHALL contain no multiplier and no reference to the F extension.

Verification
REQ-032 SHALL cover DIV 20 / -3: result 0xFFFFFFFA (-6), done at N+34; REM with the same operands gives 2.
REQ-033 SHALL cover DIVU 0xFFFFFFFF / 2: result 0x7FFFFFFF; REMU gives 1.
REQ-034 SHALL cover divide by zero: DIV 7/0 gives 0xFFFFFFFF and REM 7/0 gives 7, both with done at N+2.
REQ-035 SHALL cover overflow: DIV 0x80000000 / -1 gives 0x80000000 and REM gives 0, both with done at N+2.
REQ-036 SHALL cover kill at cycle N+10: no done, busy low at N+11, result keeps its previous value; a new start at N+12 completes normally.
REQ-037 SHALL cover start held high throughout busy (ignored), then start in the DONE cycle: two done pulses exactly 34 cycles apart.
